// File: rtl/pc_return_stack_unit.sv
// +--------------------------------------------------------------------------+
// | pc_return_stack_unit: program counter with hardware return-address stack |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pc_return_stack_unit #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    STACK_DEPTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            en_instruction_fetch,
  input  logic [1:0]                      sig_pc_src,
  input  logic                            sig_call,
  input  logic [ADDR_WIDTH-1:0]           jump_target,
  input  logic [ADDR_WIDTH-1:0]           branch_target,
  output logic [ADDR_WIDTH-1:0]           pc,
  output logic [ADDR_WIDTH-1:0]           pc_plus_one,
  output logic [ADDR_WIDTH-1:0]           stack_top,
  output logic [$clog2(STACK_DEPTH):0]    stack_count,
  output logic                            stack_full,
  output logic                            stack_empty,
  output logic                            err_overflow,
  output logic                            err_underflow
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]       sp;
  logic [IDX_W-1:0]      top_idx;

  logic [ADDR_WIDTH-1:0] next_pc;
  logic [SP_W-1:0]       next_sp;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic                  set_ovf;
  logic                  set_unf;
  logic                  pop_req;

  assign pc_plus_one = pc + ADDR_WIDTH'(1);
  assign stack_count = sp;
  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign top_idx     = IDX_W'(sp - SP_W'(1));
  assign stack_top   = stack_empty ? '0 : stack_mem[top_idx];
  assign pop_req     = (sig_pc_src == 2'd3);

  always_comb begin
    next_pc = pc_plus_one;
    next_sp = sp;
    wr_en   = 1'b0;
    wr_idx  = sp[IDX_W-1:0];
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (pop_req) begin
      if (stack_empty) begin
        // Underflow falls through to sequential fetch; a paired call still pushes.
        set_unf = 1'b1;
        if (sig_call) begin
          wr_en   = 1'b1;
          next_sp = sp + SP_W'(1);
        end
      end else begin
        next_pc = stack_top;
        if (sig_call) begin
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end else begin
          next_sp = sp - SP_W'(1);
        end
      end
    end else begin
      case (sig_pc_src)
        2'd1:    next_pc = jump_target;
        2'd2:    next_pc = branch_target;
        default: next_pc = pc_plus_one;
      endcase
      if (sig_call) begin
        if (stack_full) begin
          set_ovf = 1'b1;
        end else begin
          wr_en   = 1'b1;
          next_sp = sp + SP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc            <= RESET_VECTOR;
      sp            <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else if (en_instruction_fetch) begin
      pc            <= next_pc;
      sp            <= next_sp;
      err_overflow  <= err_overflow | set_ovf;
      err_underflow <= err_underflow | set_unf;
    end
  end

  // Stack storage is deliberately not reset; emptiness is tracked by sp alone.
  always_ff @(posedge clock) begin
    if (!reset && en_instruction_fetch && wr_en) begin
      stack_mem[wr_idx] <= pc_plus_one;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_return_stack_unit.sv
// Scoreboard bench for pc_return_stack_unit: directed vectors, queued expectations.
`default_nettype none

module tb_pc_return_stack_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en_instruction_fetch = 1'b0;
  logic [1:0]  sig_pc_src = 2'd0;
  logic        sig_call = 1'b0;
  logic [15:0] jump_target = '0;
  logic [15:0] branch_target = '0;
  logic [15:0] pc, pc_plus_one, stack_top;
  logic [3:0]  stack_count;
  logic        stack_full, stack_empty, err_overflow, err_underflow;

  pc_return_stack_unit #(.ADDR_WIDTH(16), .STACK_DEPTH(8), .RESET_VECTOR(16'h0000)) dut (
    .clock(clock), .reset(reset), .en_instruction_fetch(en_instruction_fetch),
    .sig_pc_src(sig_pc_src), .sig_call(sig_call), .jump_target(jump_target),
    .branch_target(branch_target), .pc(pc), .pc_plus_one(pc_plus_one),
    .stack_top(stack_top), .stack_count(stack_count), .stack_full(stack_full),
    .stack_empty(stack_empty), .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] top;
    logic [3:0]  count;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t q[$];
  logic obs = 1'b0;
  int   total = 0;
  int   passed = 0;
  int   ops = 0;

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s (op %0d): got %0h expected %0h", name, n, act, exp);
  endtask

  // Drive one cycle of stimulus and queue the state expected after its rising edge.
  task automatic op(input logic e, input logic r, input logic [1:0] s, input logic c,
                    input logic [15:0] t, input logic [15:0] epc, input int ecnt,
                    input logic [15:0] etop, input logic eovf, input logic eunf);
    exp_t x;
    @(negedge clock);
    en_instruction_fetch = e;
    reset         = r;
    sig_pc_src    = s;
    sig_call      = c;
    jump_target   = (s == 2'd2) ? ~t : t;
    branch_target = (s == 2'd2) ? t : ~t;
    x.pc    = epc;
    x.top   = etop;
    x.count = 4'(ecnt);
    x.ovf   = eovf;
    x.unf   = eunf;
    q.push_back(x);
    obs = 1'b1;
  endtask

  // Monitor: after every observed edge, pop the expectation and compare.
  initial begin
    exp_t x;
    forever begin
      @(posedge clock);
      if (obs) begin
        #1;
        ops++;
        if (q.size() == 0) begin
          total++;
          $display("FAIL scoreboard_underrun (op %0d): got empty queue expected entry", ops);
        end else begin
          x = q.pop_front();
          chk("pc",            ops, 32'(pc),            32'(x.pc));
          chk("pc_plus_one",   ops, 32'(pc_plus_one),   32'(16'(x.pc + 16'd1)));
          chk("stack_top",     ops, 32'(stack_top),     32'(x.top));
          chk("stack_count",   ops, 32'(stack_count),   32'(x.count));
          chk("stack_full",    ops, 32'(stack_full),    32'(x.count == 4'd8));
          chk("stack_empty",   ops, 32'(stack_empty),   32'(x.count == 4'd0));
          chk("err_overflow",  ops, 32'(err_overflow),  32'(x.ovf));
          chk("err_underflow", ops, 32'(err_underflow), 32'(x.unf));
        end
      end
    end
  end

  initial begin
    // Reset state
    op(0, 1, 2'd0, 0, 16'd0, 16'd0, 0, 16'd0, 0, 0);
    // Sequential fetch, then hold with garbage inputs while enable is low
    for (int i = 1; i <= 4; i++) op(1, 0, 2'd0, 0, 16'd0, 16'(i), 0, 16'd0, 0, 0);
    repeat (3) op(0, 0, 2'd1, 1, 16'd99, 16'd4, 0, 16'd0, 0, 0);
    // Wrap-around of pc+1
    op(1, 0, 2'd1, 0, 16'hFFFF, 16'hFFFF, 0, 16'd0, 0, 0);
    op(1, 0, 2'd0, 0, 16'd0,    16'd0,    0, 16'd0, 0, 0);
    // Single call and return
    op(1, 0, 2'd1, 0, 16'd5,  16'd5,  0, 16'd0, 0, 0);
    op(1, 0, 2'd1, 1, 16'd40, 16'd40, 1, 16'd6, 0, 0);
    op(1, 0, 2'd3, 0, 16'd0,  16'd6,  0, 16'd0, 0, 0);
    // Nested calls from 10..80 fill the stack; the ninth overflows
    op(1, 0, 2'd1, 0, 16'd10, 16'd10, 0, 16'd0, 0, 0);
    for (int i = 1; i <= 8; i++)
      op(1, 0, 2'd1, 1, 16'(10*(i+1)), 16'(10*(i+1)), i, 16'(10*i+1), 0, 0);
    op(1, 0, 2'd1, 1, 16'd200, 16'd200, 8, 16'd81, 1, 0);
    for (int k = 1; k <= 8; k++)
      op(1, 0, 2'd3, 0, 16'd0, 16'(10*(9-k)+1), 8-k,
         (k < 8) ? 16'(10*(8-k)+1) : 16'd0, 1, 0);
    // Return on empty stack
    op(1, 0, 2'd1, 0, 16'd7, 16'd7, 0, 16'd0, 1, 0);
    op(1, 0, 2'd3, 0, 16'd0, 16'd8, 0, 16'd0, 1, 1);
    op(1, 0, 2'd0, 0, 16'd0, 16'd9, 0, 16'd0, 1, 1);
    // Branch leaves the stack alone; then simultaneous pop+push
    op(1, 0, 2'd2, 0, 16'd100, 16'd100, 0, 16'd0,  1, 1);
    op(1, 0, 2'd1, 0, 16'd49,  16'd49,  0, 16'd0,  1, 1);
    op(1, 0, 2'd1, 1, 16'd30,  16'd30,  1, 16'd50, 1, 1);
    op(1, 0, 2'd3, 1, 16'd0,   16'd50,  1, 16'd31, 1, 1);
    op(1, 0, 2'd3, 0, 16'd0,   16'd31,  0, 16'd0,  1, 1);
    // Pop+push on empty: underflow path, push still happens
    op(1, 0, 2'd3, 1, 16'd0,   16'd32,  1, 16'd32, 1, 1);
    // Reset during an enabled call discards the update and clears flags
    op(1, 1, 2'd1, 1, 16'd500, 16'd0,   0, 16'd0,  0, 0);
    op(1, 0, 2'd0, 0, 16'd0,   16'd1,   0, 16'd0,  0, 0);
    op(0, 0, 2'd3, 1, 16'd0,   16'd1,   0, 16'd0,  0, 0);

    @(negedge clock);
    en_instruction_fetch = 1'b0;
    obs = 1'b0;
    for (int w = 0; w < 10 && q.size() != 0; w++) @(negedge clock);
    if (q.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
